set_bit_iterator: RTL and testbench
===================================

# set_bit_iterator

Sequential, parametrised successor to the combinational lowest/second-lowest set-bit extractors. Accepts one WIDTH-bit vector through a valid/ready handshake, then streams its set bits LSB-first, one one-hot beat per cycle, numbering each beat with its ordinal. An optional limit stops the stream after the K-th set bit, so one block serves first-bit, second-bit and K-th-bit extraction. It sits between a request/flag vector producer and any consumer that services set bits one at a time, such as an arbiter, an interrupt walker or a free-list allocator.

## Interface
- `WIDTH`, default 12: vector width, must be ≥ 2.
- `CNT_W`, default `$clog2(WIDTH+1)`: width of the ordinal and limit fields.
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `in_valid_i` in 1: input vector valid.
- `in_ready_o` out 1: block can accept a vector.
- `vec_i` in WIDTH: vector to iterate.
- `limit_i` in CNT_W: maximum beats to emit; 0 means unlimited. Sampled with `vec_i`.
- `out_valid_o` out 1: output beat valid.
- `out_ready_i` in 1: consumer accepts beat.
- `bit_o` out WIDTH: one-hot set bit, or 0 on an empty beat.
- `ord_o` out CNT_W: 1-based ordinal of `bit_o`, or 0 on an empty beat.
- `last_o` out 1: final beat for this vector.
- `empty_o` out 1: input vector had no set bits.
- `busy_o` out 1: iteration in progress.

## Operation
- The block has two states, IDLE and EMIT. Registered state is `rem` (WIDTH), `lim` (CNT_W) and `ord` (CNT_W).
- **IDLE**
  - `in_ready_o` = 1 and `out_valid_o` = 0.
  - On accept (`in_valid_i && in_ready_o`): `rem` ← `vec_i`, `lim` ← `limit_i`, `ord` ← 1, then go to EMIT.
- **EMIT** output values:
  - `in_ready_o` = 0 and `out_valid_o` = 1.
  - `bit_o` = `rem & (~rem + 1)`.
  - `ord_o` = `ord`.
  - `empty_o` = (`rem` == 0). This can only be true on the first beat.
  - `last_o` = `empty_o` OR (`rem & ~bit_o`) == 0 OR (`lim` != 0 AND `ord` == `lim`).
- **EMIT** on output handshake (`out_valid_o && out_ready_i`):
  - If `last_o`, go to IDLE.
  - Otherwise `rem` ← `rem & ~bit_o` and `ord` ← `ord` + 1.
- **Backpressure:** while `out_valid_o && !out_ready_i`, every output holds stable.
- **Limit handling:** a `limit_i` at or above the popcount ends the stream naturally at the last set bit.
- **Ordinal width:** `ord` never exceeds WIDTH, so no wrap occurs with the default `CNT_W`.
- `busy_o` = (state == EMIT).
- **Reset:**
  - Applies in any state and discards any in-flight vector.
  - Next state is IDLE.
  - `out_valid_o`, `bit_o`, `ord_o`, `last_o`, `empty_o` and `busy_o` are all 0.
  - `in_ready_o` is 0 while `rst_i` is high and 1 from the first cycle after release.

## Timing
- **Accept to first beat:** a vector accepted at edge N produces `out_valid_o` high in the cycle after edge N (one-cycle latency).
- **Beat rate:** one beat per cycle while `out_ready_i` is held high.
- **Throughput:** the last-beat handshake at edge M puts the block in IDLE after M, and the next accept happens no earlier than edge M+1. A vector therefore occupies `beats` + 1 cycles, where `beats` = min(popcount, limit), or 1 if the vector is empty.
- **Output paths:** no combinational path from `in_valid_i` or `vec_i` to any output. `bit_o`, `last_o` and `empty_o` are combinational from registered state only.
- **Simultaneous events:** `rst_i` high at the same edge as any handshake: reset wins.

## Configuration
- `SET_BIT_ITER_INDEX_EN` defined:
  - Adds port `idx_o`, out, `IDX_W` = `$clog2(WIDTH)`.
  - `idx_o` is the binary position of the `bit_o` one-hot, valid with `out_valid_o`, and 0 on an empty beat or in reset.
- `SET_BIT_ITER_INDEX_EN` undefined: `idx_o` and its encoder are absent. All other behaviour is identical.

## Test plan
- **Basic stream:** `vec_i` = 12'h068, `limit_i` = 0, `out_ready_i` = 1. Required response is exactly three beats, then IDLE:
  - `bit_o` = 12'h008, `ord_o` = 1;
  - `bit_o` = 12'h020, `ord_o` = 2;
  - `bit_o` = 12'h040, `ord_o` = 3, `last_o` = 1.
  - With `SET_BIT_ITER_INDEX_EN`, `idx_o` is 3, 5, 6.
- **Second-bit mode:** `vec_i` = 12'h0A4, `limit_i` = 2. Required response is exactly two beats, 12'h004 then 12'h020, with `last_o` = 1 on the second.
- **Empty vector:** `vec_i` = 0. Required response is one beat with `bit_o` = 0, `ord_o` = 0, `empty_o` = 1, `last_o` = 1.
- **Backpressure:** `vec_i` = 12'hFFF with `out_ready_i` toggling 1,0,0,1,… Required response:
  - Outputs stay stable during stalls.
  - The stream has 12 beats with `ord_o` = 1..12, and beat 12 is `bit_o` = 12'h800 with `last_o` = 1.
  - `in_ready_o` is 0 throughout.
- **Reset mid-stream:** `vec_i` = 12'h0F0, `rst_i` pulsed for one cycle after beat 2. Required response:
  - During reset, `out_valid_o` = 0 and `busy_o` = 0.
  - `in_ready_o` = 1 on the cycle after release.
  - A new vector 12'h001 gives a single beat `bit_o` = 12'h001, `ord_o` = 1, `last_o` = 1.
- **Back-to-back:** hold `in_valid_i` high with 12'h003 followed by 12'h800. Required response:
  - The second accept happens exactly one cycle after the first vector's last-beat handshake.
  - Beats are 12'h001, 12'h002, then 12'h800 with `last_o` = 1.

Source files
------------

// File: rtl/set_bit_iterator.sv
// rtl/set_bit_iterator.sv - streams the set bits of an accepted vector LSB-first, one one-hot beat per cycle
//
// Accepts one WIDTH-bit vector over a valid/ready handshake. It then emits
// one beat per set bit, lowest bit first. Each beat carries a 1-based
// ordinal. A non-zero limit ends the stream after that many beats.
// An all-zero vector produces a single empty beat.
//
// Optional feature macro: SET_BIT_ITER_INDEX_EN. When it is defined, the
// block adds port idx_o, the binary position of bit_o.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   in_valid_i   input vector valid
//   in_ready_o   block can accept a vector (IDLE and not in reset)
//   vec_i        vector to iterate
//   limit_i      max beats to emit, 0 = unlimited; sampled with vec_i
//   out_valid_o  output beat valid
//   out_ready_i  consumer accepts beat
//   bit_o        one-hot set bit, 0 on an empty beat
//   ord_o        1-based ordinal of bit_o, 0 on an empty beat
//   last_o       final beat for this vector
//   empty_o      accepted vector had no set bits
//   busy_o       iteration in progress
//   idx_o        (SET_BIT_ITER_INDEX_EN only) binary index of bit_o

module set_bit_iterator #(
   parameter int WIDTH = 12,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   input  logic [WIDTH-1:0]           vec_i,
   input  logic [CNT_W-1:0]           limit_i,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic [WIDTH-1:0]           bit_o,
   output logic [CNT_W-1:0]           ord_o,
   output logic                       last_o,
   output logic                       empty_o,
`ifdef SET_BIT_ITER_INDEX_EN
   output logic                       busy_o,
   output logic [$clog2(WIDTH)-1:0]   idx_o
`else
   output logic                       busy_o
`endif
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_d;

   logic [WIDTH-1:0]  r_rem;
   logic [CNT_W-1:0]  r_lim;
   logic [CNT_W-1:0]  r_ord;

   logic [WIDTH-1:0]  w_rem_d;
   logic [CNT_W-1:0]  w_lim_d;
   logic [CNT_W-1:0]  w_ord_d;

   logic [WIDTH-1:0]  w_lowest;
   logic [WIDTH-1:0]  w_rem_rest;
   logic              w_empty;
   logic              w_last;
   logic              w_emit;
   logic              w_accept;
   logic              w_beat_hs;

   // Isolate the lowest set bit with two's-complement arithmetic.
   // The remainder after clearing it decides whether this beat is the last.
   always_comb begin
      w_lowest   = r_rem & (~r_rem + WIDTH'(1));
      w_rem_rest = r_rem & ~w_lowest;
      w_empty    = (r_rem == '0);
      w_last     = w_empty || (w_rem_rest == '0) ||
                   ((r_lim != '0) && (r_ord == r_lim));
   end

   // The outputs are gated by rst_i so that they read as zero while reset
   // is asserted, even before the reset edge has been taken.
   always_comb begin
      w_emit      = (r_state == ST_EMIT) && !rst_i;
      in_ready_o  = (r_state == ST_IDLE) && !rst_i;
      out_valid_o = w_emit;
      busy_o      = w_emit;
      bit_o       = w_emit ? w_lowest : '0;
      ord_o       = (w_emit && !w_empty) ? r_ord : '0;
      last_o      = w_emit && w_last;
      empty_o     = w_emit && w_empty;
      w_accept    = in_valid_i && in_ready_o;
      w_beat_hs   = out_valid_o && out_ready_i;
   end

   // Next-state and datapath update
   always_comb begin
      w_state_d = r_state;
      w_rem_d   = r_rem;
      w_lim_d   = r_lim;
      w_ord_d   = r_ord;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_d = ST_EMIT;
               w_rem_d   = vec_i;
               w_lim_d   = limit_i;
               w_ord_d   = CNT_W'(1);
            end
         end
         ST_EMIT: begin
            if (w_beat_hs) begin
               if (w_last) begin
                  w_state_d = ST_IDLE;
               end else begin
                  w_rem_d = w_rem_rest;
                  w_ord_d = r_ord + CNT_W'(1);
               end
            end
         end
         default: w_state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_rem   <= '0;
         r_lim   <= '0;
         r_ord   <= '0;
      end else begin
         r_state <= w_state_d;
         r_rem   <= w_rem_d;
         r_lim   <= w_lim_d;
         r_ord   <= w_ord_d;
      end
   end

`ifdef SET_BIT_ITER_INDEX_EN
   localparam int IDX_W = $clog2(WIDTH);

   // bit_o is one-hot or zero, so an OR-reduction encoder is enough.
   // It reads 0 for an empty beat and in reset.
   always_comb begin
      idx_o = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (bit_o[i]) begin
            idx_o = idx_o | IDX_W'(i);
         end
      end
   end
`endif

endmodule

// File: tb/tb_set_bit_iterator.sv
// tb/tb_set_bit_iterator.sv - self-checking bench for set_bit_iterator
module tb_set_bit_iterator;
   localparam int W  = 12;
   localparam int CW = $clog2(W + 1);

   logic          clk = 1'b0;
   logic          rst_i;
   logic          in_valid_i;
   logic          in_ready_o;
   logic [W-1:0]  vec_i;
   logic [CW-1:0] limit_i;
   logic          out_valid_o;
   logic          out_ready_i;
   logic [W-1:0]  bit_o;
   logic [CW-1:0] ord_o;
   logic          last_o;
   logic          empty_o;
   logic          busy_o;
`ifdef SET_BIT_ITER_INDEX_EN
   logic [$clog2(W)-1:0] idx_o;
`endif

   set_bit_iterator #(.WIDTH(W)) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .vec_i       (vec_i),
      .limit_i     (limit_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .bit_o       (bit_o),
      .ord_o       (ord_o),
      .last_o      (last_o),
      .empty_o     (empty_o),
`ifdef SET_BIT_ITER_INDEX_EN
      .busy_o      (busy_o),
      .idx_o       (idx_o)
`else
      .busy_o      (busy_o)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0]  b;
      logic [CW-1:0] o;
      logic          l;
      logic          e;
      int            idx;
   } beat_t;

   beat_t exp_q[$];
   beat_t log_q[$];
   int    acc_cyc[$];
   int    lasths_cyc[$];
   int    n_tests = 0;
   int    n_fail  = 0;
   int    cyc     = 0;
   int    rdy_mode = 0;
   int    rdy_k    = 0;
   bit    pend_acc = 0;
   bit    stalled  = 0;
   beat_t prev;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Reference model: enumerate the set bits of the vector in ascending
   // position order and stop after lim of them (lim == 0 means no limit).
   task automatic push_model(input logic [W-1:0] v, input int lim);
      beat_t bt;
      int n = 0;
      logic [W-1:0] hi;
      if (v == 0) begin
         bt.b = '0; bt.o = '0; bt.l = 1'b1; bt.e = 1'b1; bt.idx = 0;
         exp_q.push_back(bt);
         return;
      end
      for (int i = 0; i < W; i++) begin
         if (v[i]) begin
            n++;
            hi = v >> (i + 1);
            bt.b = '0;
            bt.b[i] = 1'b1;
            bt.o = CW'(n);
            bt.e = 1'b0;
            bt.idx = i;
            bt.l = (hi == 0) || (lim != 0 && n == lim);
            exp_q.push_back(bt);
            if (bt.l) break;
         end
      end
   endtask

   // out_ready_i pattern: mode 0 = always 1, mode 1 = 1,0,0 repeating
   always @(posedge clk) begin
      #1;
      if (rdy_mode == 0) out_ready_i = 1'b1;
      else begin
         out_ready_i = (rdy_k % 3 == 0);
         rdy_k++;
      end
   end

   // Compare process: the inputs change only just after a rising edge, so
   // the values seen at the falling edge are what the next rising edge samples.
   always @(negedge clk) begin
      beat_t obs;
      obs.b = bit_o; obs.o = ord_o; obs.l = last_o; obs.e = empty_o;
`ifdef SET_BIT_ITER_INDEX_EN
      obs.idx = int'(idx_o);
`else
      obs.idx = 0;
`endif
      if (rst_i) begin
         exp_q.delete();
         pend_acc = 0;
         stalled  = 0;
      end else begin
         if (pend_acc) chk("accept_latency_valid", out_valid_o, 1);
         if (out_valid_o) begin
            chk("emit_in_ready_low", in_ready_o, 0);
            chk("emit_busy", busy_o, 1);
            if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
            else begin
               chk("beat_bit",   obs.b, exp_q[0].b);
               chk("beat_ord",   obs.o, exp_q[0].o);
               chk("beat_last",  obs.l, exp_q[0].l);
               chk("beat_empty", obs.e, exp_q[0].e);
`ifdef SET_BIT_ITER_INDEX_EN
               chk("beat_idx", obs.idx, exp_q[0].idx);
`endif
            end
            if (stalled) begin
               chk("stall_bit",  obs.b, prev.b);
               chk("stall_ord",  obs.o, prev.o);
               chk("stall_last", obs.l, prev.l);
            end
            if (out_ready_i) begin
               log_q.push_back(obs);
               if (exp_q.size() != 0) void'(exp_q.pop_front());
               if (last_o) lasths_cyc.push_back(cyc);
               stalled = 0;
            end else begin
               stalled = 1;
               prev = obs;
            end
         end else begin
            stalled = 0;
            chk("idle_in_ready", in_ready_o, 1);
            chk("idle_busy", busy_o, 0);
         end
         pend_acc = 0;
         if (in_valid_i && in_ready_o) begin
            push_model(vec_i, int'(limit_i));
            acc_cyc.push_back(cyc);
            pend_acc = 1;
         end
      end
   end

   task automatic send(input logic [W-1:0] v, input logic [CW-1:0] lim);
      int t = 0;
      @(posedge clk); #1;
      in_valid_i = 1'b1; vec_i = v; limit_i = lim;
      do begin
         @(negedge clk);
         t++;
      end while (!in_ready_o && t < 100);
      chk("send_timeout", t < 100, 1);
      @(posedge clk); #1;
      in_valid_i = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int t = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || busy_o) && t < 300) begin
         @(negedge clk);
         t++;
      end
      chk(name, t < 300, 1);
   endtask

   task automatic chk_beat(input string nm, input int i, input logic [W-1:0] b,
                           input int o, input logic l, input logic e);
      if (i < log_q.size()) begin
         chk({nm, "_bit"},  log_q[i].b, b);
         chk({nm, "_ord"},  log_q[i].o, o);
         chk({nm, "_last"}, log_q[i].l, l);
         chk({nm, "_empty"}, log_q[i].e, e);
      end else chk({nm, "_missing"}, log_q.size(), i + 1);
   endtask

   initial begin
      int t;
      rst_i = 1'b1; in_valid_i = 1'b0; vec_i = '0; limit_i = '0; out_ready_i = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("rst_out_valid", out_valid_o, 0);
         chk("rst_in_ready", in_ready_o, 0);
         chk("rst_busy", busy_o, 0);
         chk("rst_bit", bit_o, 0);
         chk("rst_ord", ord_o, 0);
         chk("rst_last", last_o, 0);
         chk("rst_empty", empty_o, 0);
      end
      @(posedge clk); #1;
      rst_i = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", in_ready_o, 1);

      // Basic stream
      log_q.delete();
      send(12'h068, 0);
      wait_idle("basic_timeout");
      chk("basic_count", log_q.size(), 3);
      chk_beat("basic0", 0, 12'h008, 1, 0, 0);
      chk_beat("basic1", 1, 12'h020, 2, 0, 0);
      chk_beat("basic2", 2, 12'h040, 3, 1, 0);
`ifdef SET_BIT_ITER_INDEX_EN
      if (log_q.size() == 3) begin
         chk("basic_idx0", log_q[0].idx, 3);
         chk("basic_idx1", log_q[1].idx, 5);
         chk("basic_idx2", log_q[2].idx, 6);
      end
`endif

      // Second-bit mode
      log_q.delete();
      send(12'h0A4, 2);
      wait_idle("second_timeout");
      chk("second_count", log_q.size(), 2);
      chk_beat("second0", 0, 12'h004, 1, 0, 0);
      chk_beat("second1", 1, 12'h020, 2, 1, 0);

      // Empty vector
      log_q.delete();
      send(12'h000, 0);
      wait_idle("empty_timeout");
      chk("empty_count", log_q.size(), 1);
      chk_beat("empty0", 0, 12'h000, 0, 1, 1);

      // Limit at popcount and above popcount
      log_q.delete();
      send(12'h105, 5);
      wait_idle("limhi_timeout");
      chk("limhi_count", log_q.size(), 3);
      chk_beat("limhi2", 2, 12'h100, 3, 1, 0);

      // Backpressure
      log_q.delete();
      rdy_k = 0; rdy_mode = 1;
      send(12'hFFF, 0);
      wait_idle("bp_timeout");
      rdy_mode = 0;
      chk("bp_count", log_q.size(), 12);
      for (int i = 0; i < 12; i++)
         chk_beat("bp", i, W'(1) << i, i + 1, (i == 11), 0);

      // Reset mid-stream
      log_q.delete();
      send(12'h0F0, 0);
      t = 0;
      while (log_q.size() < 2 && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("midrst_wait", t < 100, 1);
      @(posedge clk); #1;
      rst_i = 1'b1;
      @(negedge clk);
      chk("midrst_out_valid", out_valid_o, 0);
      chk("midrst_busy", busy_o, 0);
      chk("midrst_in_ready", in_ready_o, 0);
      @(posedge clk); #1;
      rst_i = 1'b0;
      @(negedge clk);
      chk("midrst_release_ready", in_ready_o, 1);
      chk("midrst_release_valid", out_valid_o, 0);
      log_q.delete();
      send(12'h001, 0);
      wait_idle("midrst_new_timeout");
      chk("midrst_new_count", log_q.size(), 1);
      chk_beat("midrst_new0", 0, 12'h001, 1, 1, 0);

      // Back-to-back with in_valid_i held high
      log_q.delete(); acc_cyc.delete(); lasths_cyc.delete();
      @(posedge clk); #1;
      in_valid_i = 1'b1; vec_i = 12'h003; limit_i = 0;
      t = 0;
      do begin @(negedge clk); t++; end while (!in_ready_o && t < 100);
      @(posedge clk); #1;
      vec_i = 12'h800;
      do begin @(negedge clk); t++; end while (!in_ready_o && t < 100);
      chk("b2b_wait", t < 100, 1);
      @(posedge clk); #1;
      in_valid_i = 1'b0;
      wait_idle("b2b_timeout");
      chk("b2b_count", log_q.size(), 3);
      chk_beat("b2b0", 0, 12'h001, 1, 0, 0);
      chk_beat("b2b1", 1, 12'h002, 2, 1, 0);
      chk_beat("b2b2", 2, 12'h800, 1, 1, 0);
      chk("b2b_acc_count", acc_cyc.size(), 2);
      if (acc_cyc.size() == 2 && lasths_cyc.size() >= 1)
         chk("b2b_gap", acc_cyc[1] - lasths_cyc[0], 1);
      else chk("b2b_gap_events", lasths_cyc.size(), 2);

      chk("model_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1);
   end
endmodule
